// File: rtl/mixer_sched_pkg.sv
// rtl/mixer_sched_pkg.sv - shared widths and saturation helper for the mixer scheduler.
package mixer_sched_pkg;

    localparam int DEF_DW     = 20;
    localparam int DEF_NUM_CH = 4;
    localparam int CHW        = $clog2(DEF_NUM_CH);
    localparam int ACCW       = DEF_DW + CHW;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v,
                                                      input int               w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mixer_scheduler_rr_arbiter.sv
// rtl/mixer_scheduler_rr_arbiter.sv - combinational round-robin pick starting at a pointer.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [CW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CW-1:0]     grant_idx_o,
    output logic              grant_any_o
);

    always_comb begin
        int j;
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        j           = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (int'(ptr_i) + i) % NUM_CH;
            if (!grant_any_o && eligible_i[j]) begin
                grant_any_o = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = CW'(j);
            end
        end
    end

endmodule

// File: rtl/mixer_scheduler.sv
// rtl/mixer_scheduler.sv - round-robin sharing of one mixer across channels with frame summing.
module mixer_scheduler
    import mixer_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req_valid,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH*DW-1:0]      req_interp,
    input  logic [NUM_CH*DW-1:0]      req_lo,
    output logic [DW-1:0]             mix_interp_o,
    output logic [DW-1:0]             mix_lo_o,
    input  logic [DW-1:0]             mix_i,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NUM_CH)-1:0] rsp_ch,
    output logic [DW-1:0]             rsp_data,
    output logic                      frame_valid,
    output logic [DW-1:0]             frame_sum
);

    localparam int CW = $clog2(NUM_CH);
    localparam int AW = DW + CW;

    logic [NUM_CH-1:0]   served_q, served_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic                op_valid_q, op_valid_d;
    logic [CW-1:0]       op_ch_q, op_ch_d;
    logic [DW-1:0]       op_interp_q, op_interp_d;
    logic [DW-1:0]       op_lo_q, op_lo_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]       rsp_ch_q, rsp_ch_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                frame_valid_q, frame_valid_d;
    logic [DW-1:0]       frame_sum_q, frame_sum_d;

    logic                stall;
    logic                rsp_hs;
    logic                frame_done;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant;
    logic [CW-1:0]       grant_idx;
    logic                grant_any;
    logic signed [AW-1:0] rsp_ext;
    logic signed [AW-1:0] acc_sum;

    assign stall  = rsp_valid_q && !rsp_ready;
    assign rsp_hs = rsp_valid_q && rsp_ready;
    // Last outstanding result: everyone served and nothing left in stage 1.
    assign frame_done = rsp_hs && (&served_q) && !op_valid_q;

    // Gating with reset_n keeps req_ready low while the block is held in reset.
    assign eligible = req_valid & ~served_q & {NUM_CH{~stall}} & {NUM_CH{reset_n}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_arb (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign rsp_ext = AW'($signed(rsp_data_q));
    assign acc_sum = acc_q + rsp_ext;

    always_comb begin
        served_d      = served_q | grant;
        ptr_d         = ptr_q;
        op_valid_d    = op_valid_q;
        op_ch_d       = op_ch_q;
        op_interp_d   = op_interp_q;
        op_lo_d       = op_lo_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_ch_d      = rsp_ch_q;
        rsp_data_d    = rsp_data_q;
        acc_d         = acc_q;
        frame_valid_d = 1'b0;
        frame_sum_d   = frame_sum_q;

        if (grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end

        // Whole pipeline freezes under stall so mix_i stays stable on frozen operands.
        if (!stall) begin
            op_valid_d  = grant_any;
            if (grant_any) begin
                op_ch_d     = grant_idx;
                op_interp_d = req_interp[int'(grant_idx)*DW +: DW];
                op_lo_d     = req_lo[int'(grant_idx)*DW +: DW];
            end
            rsp_valid_d = op_valid_q;
            if (op_valid_q) begin
                rsp_ch_d   = op_ch_q;
                rsp_data_d = mix_i;
            end
        end

        if (rsp_hs) begin
            if (frame_done) begin
                acc_d         = '0;
                served_d      = '0;
                frame_valid_d = 1'b1;
                frame_sum_d   = DW'(sat_to_dw(64'(acc_sum), DW));
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            served_q      <= '0;
            ptr_q         <= '0;
            op_valid_q    <= 1'b0;
            op_ch_q       <= '0;
            op_interp_q   <= '0;
            op_lo_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_ch_q      <= '0;
            rsp_data_q    <= '0;
            acc_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_sum_q   <= '0;
        end else begin
            served_q      <= served_d;
            ptr_q         <= ptr_d;
            op_valid_q    <= op_valid_d;
            op_ch_q       <= op_ch_d;
            op_interp_q   <= op_interp_d;
            op_lo_q       <= op_lo_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ch_q      <= rsp_ch_d;
            rsp_data_q    <= rsp_data_d;
            acc_q         <= acc_d;
            frame_valid_q <= frame_valid_d;
            frame_sum_q   <= frame_sum_d;
        end
    end

    assign req_ready    = grant;
    assign mix_interp_o = op_interp_q;
    assign mix_lo_o     = op_lo_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_ch       = rsp_ch_q;
    assign rsp_data     = rsp_data_q;
    assign frame_valid  = frame_valid_q;
    assign frame_sum    = frame_sum_q;

endmodule
